// File: rtl/midi_note_tracker_pkg.sv
// Shared MIDI status constants, parser states and stack op encodings for midi_note_tracker.
package synth_pkg;

  localparam logic [3:0] NOTE_OFF       = 4'h8;
  localparam logic [3:0] NOTE_ON        = 4'h9;
  localparam logic [7:0] SYSCOMMON_BASE = 8'hF0;
  localparam logic [7:0] REALTIME_BASE  = 8'hF8;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} parse_state_t;

  typedef enum logic [1:0] {NONE, PUSH, REMOVE} stack_op_t;

  function automatic logic is_note_status(input logic [7:0] b);
    return (b[7:4] == NOTE_ON) || (b[7:4] == NOTE_OFF);
  endfunction

endpackage

// File: rtl/midi_note_tracker_if.sv
// Byte input and note/gate output bundle between the UART receiver, midi_note_tracker and the NCO/envelope.
interface midi_note_tracker_if #(parameter int MIDI_BITS = 7);

  logic [7:0]           byte_i;
  logic                 byte_valid_i;
  logic [MIDI_BITS-1:0] midi_note_o;
  logic [MIDI_BITS-1:0] velocity_o;
  logic                 gate_o;
  logic                 note_change_o;
  logic                 overflow_o;

  modport master (
    output byte_i, byte_valid_i,
    input  midi_note_o, velocity_o, gate_o, note_change_o, overflow_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output midi_note_o, velocity_o, gate_o, note_change_o, overflow_o
  );

endinterface

// File: rtl/midi_note_tracker_note_stack.sv
// Last-note-priority stack of held {note, velocity} entries, index 0 is the oldest.
// Latency: op applied on the next edge; top/count/evict outputs show the post-op stack combinationally.
// Backpressure: none, one op per cycle always accepted.
module note_stack
  import synth_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 7,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  stack_op_t     op_i,
  input  logic [W-1:0]  note_i,
  input  logic [W-1:0]  vel_i,
  output logic [W-1:0]  top_note_o,
  output logic [W-1:0]  top_vel_o,
  output logic [CW-1:0] count_o,
  output logic          evict_o
);

  logic [W-1:0]     note_q [DEPTH];
  logic [W-1:0]     vel_q  [DEPTH];
  logic [W-1:0]     note_d [DEPTH];
  logic [W-1:0]     vel_d  [DEPTH];
  logic [CW-1:0]    count_q, count_d, wr_ptr;
  logic [DEPTH-1:0] match, gap;
  logic             hit, full, shift_en;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = (CW'(i) < count_q) && (note_q[i] == note_i);
    end
    hit      = |match;
    full     = (count_q == CW'(DEPTH));
    shift_en = (op_i != NONE);
    evict_o  = (op_i == PUSH) && !hit && full;

    // gap[i] set means entry i is refilled from i+1 (matched entry removed or bottom evicted)
    gap    = '0;
    gap[0] = shift_en && (match[0] || evict_o);
    for (int i = 1; i < DEPTH; i++) begin
      gap[i] = gap[i-1] || (shift_en && match[i]);
    end

    for (int i = 0; i < DEPTH; i++) begin
      note_d[i] = note_q[i];
      vel_d[i]  = vel_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (gap[i]) begin
        note_d[i] = note_q[i+1];
        vel_d[i]  = vel_q[i+1];
      end
    end

    count_d = count_q;
    wr_ptr  = '0;
    case (op_i)
      PUSH: begin
        if (!hit && !full) begin
          count_d = count_q + CW'(1);
        end
        wr_ptr = count_d - CW'(1);
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_ptr) begin
            note_d[i] = note_i;
            vel_d[i]  = vel_i;
          end
        end
      end
      REMOVE: begin
        if (hit) begin
          count_d = count_q - CW'(1);
        end
      end
      default: ;
    endcase

    top_note_o = '0;
    top_vel_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) + CW'(1) == count_d) begin
        top_note_o = note_d[i];
        top_vel_o  = vel_d[i];
      end
    end
    count_o = count_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        note_q[i] <= note_d[i];
        vel_q[i]  <= vel_d[i];
      end
    end
  end

endmodule

// File: rtl/midi_note_tracker.sv
// MIDI Note On/Off parser with running status feeding a last-note-priority stack; MIDI_NOTE_TRACKER_OMNI_EN accepts every channel.
// Latency: second data byte captured on edge N, stack updated and outputs registered on edge N+1.
// Backpressure: none, one byte per clock always accepted.
module midi_note_tracker
  import synth_pkg::*;
#(
  parameter int MIDI_BITS   = 7,
  parameter int STACK_DEPTH = 8,
  parameter int CHANNEL     = 0
) (
  input logic               clk_i,
  input logic               rst_i,
  midi_note_tracker_if.slave bus
);

  localparam int CW = $clog2(STACK_DEPTH + 1);

  parse_state_t         state_q, state_d;
  logic                 note_on_q, note_on_d;
  logic [MIDI_BITS-1:0] data_note_q, data_note_d;
  logic [MIDI_BITS-1:0] op_vel_q, op_vel_d;
  stack_op_t            op_q, op_d;
  logic                 chan_ok;

  logic [MIDI_BITS-1:0] nxt_note, nxt_vel;
  logic [CW-1:0]        nxt_count;
  logic                 evict, gate_d;

  always_comb begin
`ifdef MIDI_NOTE_TRACKER_OMNI_EN
    chan_ok = 1'b1;
`else
    chan_ok = (bus.byte_i[3:0] == 4'(CHANNEL));
`endif
  end

  always_comb begin
    state_d     = state_q;
    note_on_d   = note_on_q;
    data_note_d = data_note_q;
    op_vel_d    = op_vel_q;
    op_d        = NONE;
    // realtime bytes fall through untouched so they can sit inside a message
    if (bus.byte_valid_i && (bus.byte_i < REALTIME_BASE)) begin
      if (bus.byte_i >= SYSCOMMON_BASE) begin
        state_d   = IDLE;
        note_on_d = 1'b0;
      end else if (bus.byte_i[7]) begin
        note_on_d = (bus.byte_i[7:4] == NOTE_ON);
        state_d   = (is_note_status(bus.byte_i) && chan_ok) ? WAIT_D1 : SKIP;
      end else begin
        case (state_q)
          WAIT_D1: begin
            data_note_d = MIDI_BITS'(bus.byte_i[6:0]);
            state_d     = WAIT_D2;
          end
          WAIT_D2: begin
            op_vel_d = MIDI_BITS'(bus.byte_i[6:0]);
            op_d     = (note_on_q && (bus.byte_i[6:0] != 7'd0)) ? PUSH : REMOVE;
            state_d  = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      note_on_q   <= 1'b0;
      data_note_q <= '0;
      op_vel_q    <= '0;
      op_q        <= NONE;
    end else begin
      state_q     <= state_d;
      note_on_q   <= note_on_d;
      data_note_q <= data_note_d;
      op_vel_q    <= op_vel_d;
      op_q        <= op_d;
    end
  end

  note_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (MIDI_BITS)
  ) u_stack (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .op_i       (op_q),
    .note_i     (data_note_q),
    .vel_i      (op_vel_q),
    .top_note_o (nxt_note),
    .top_vel_o  (nxt_vel),
    .count_o    (nxt_count),
    .evict_o    (evict)
  );

  assign gate_d = (nxt_count != '0);

  // note/velocity freeze when the stack empties so the envelope release keeps its pitch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.midi_note_o   <= '0;
      bus.velocity_o    <= '0;
      bus.gate_o        <= 1'b0;
      bus.note_change_o <= 1'b0;
      bus.overflow_o    <= 1'b0;
    end else begin
      bus.gate_o        <= gate_d;
      bus.note_change_o <= (gate_d != bus.gate_o) || (gate_d && (nxt_note != bus.midi_note_o));
      bus.overflow_o    <= bus.overflow_o || evict;
      if (gate_d) begin
        bus.midi_note_o <= nxt_note;
        bus.velocity_o  <= nxt_vel;
      end
    end
  end

endmodule

// File: tb/tb_midi_note_tracker.sv
// Scoreboarded random/directed bench for midi_note_tracker against a queue-based note model.
module tb_midi_note_tracker;

  localparam int MB    = 7;
  localparam int DEPTH = 8;
  localparam int CHAN  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  midi_note_tracker_if #(.MIDI_BITS(MB)) bus ();

  midi_note_tracker #(
    .MIDI_BITS   (MB),
    .STACK_DEPTH (DEPTH),
    .CHANNEL     (CHAN)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [6:0] note;
    logic [6:0] vel;
    logic       gate;
    logic       ovf;
    logic       chg;
  } exp_t;

  typedef struct packed {
    logic [6:0] note;
    logic [6:0] vel;
  } ent_t;

  exp_t exp_q[$];
  ent_t held[$];

  // model: listening flag, message type, partial note
  logic       m_armed, m_on, m_have;
  logic [6:0] m_pnote;
  logic [6:0] m_note, m_vel;
  logic       m_gate, m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic void model_reset();
    held.delete();
    m_armed = 1'b0; m_on = 1'b0; m_have = 1'b0; m_pnote = '0;
    m_note = '0; m_vel = '0; m_gate = 1'b0; m_ovf = 1'b0;
  endfunction

  function automatic logic model_apply(input logic push, input logic [6:0] n, input logic [6:0] v);
    int   idx;
    ent_t e;
    logic ng;
    logic [6:0] nn;
    logic chg;
    idx = -1;
    foreach (held[i]) if (held[i].note == n) idx = i;
    if (push) begin
      if (idx >= 0) held.delete(idx);
      else if (held.size() == DEPTH) begin
        held.delete(0);
        m_ovf = 1'b1;
      end
      e.note = n; e.vel = v;
      held.push_back(e);
    end else if (idx >= 0) begin
      held.delete(idx);
    end
    ng  = (held.size() > 0);
    nn  = ng ? held[$].note : m_note;
    chg = (ng != m_gate) || (nn != m_note);
    if (ng) begin
      m_note = held[$].note;
      m_vel  = held[$].vel;
    end
    m_gate = ng;
    return chg;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic chg;
    logic chan_ok;
    exp_t e;
    chg = 1'b0;
`ifdef MIDI_NOTE_TRACKER_OMNI_EN
    chan_ok = 1'b1;
`else
    chan_ok = (b[3:0] == 4'(CHAN));
`endif
    if (b >= 8'hF8) begin
    end else if (b >= 8'hF0) begin
      m_armed = 1'b0; m_have = 1'b0;
    end else if (b >= 8'h80) begin
      m_armed = ((b[7:4] == 4'h8) || (b[7:4] == 4'h9)) && chan_ok;
      m_on    = (b[7:4] == 4'h9);
      m_have  = 1'b0;
    end else if (m_armed) begin
      if (!m_have) begin
        m_pnote = b[6:0];
        m_have  = 1'b1;
      end else begin
        chg    = model_apply(m_on && (b[6:0] != 7'd0), m_pnote, b[6:0]);
        m_have = 1'b0;
      end
    end
    e.note = m_note; e.vel = m_vel; e.gate = m_gate; e.ovf = m_ovf; e.chg = chg;
    exp_q.push_back(e);
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.byte_valid_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_note", bus.midi_note_o, 0);
    check("rst_vel", bus.velocity_o, 0);
    check("rst_gate", bus.gate_o, 0);
    check("rst_chg", bus.note_change_o, 0);
    check("rst_ovf", bus.overflow_o, 0);
    rst = 1'b0;
  endtask

  // monitor: each accepted byte has its effect visible after the following edge
  initial begin
    logic [1:0] hist;
    exp_t e;
    hist = 2'b00;
    forever begin
      @(posedge clk);
      hist = rst ? 2'b00 : {hist[0], bus.byte_valid_i};
      @(negedge clk);
      if (rst) begin
      end else if (hist[1]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: output seen with no expected entry");
        end else begin
          e = exp_q.pop_front();
          check("note", bus.midi_note_o, e.note);
          check("vel", bus.velocity_o, e.vel);
          check("gate", bus.gate_o, e.gate);
          check("overflow", bus.overflow_o, e.ovf);
          check("note_change", bus.note_change_o, e.chg);
        end
      end else begin
        check("idle_note_change", bus.note_change_o, 0);
      end
    end
  end

  initial begin
    int r;
    logic [7:0] b;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    model_reset();
    idle(2);
    do_reset();

    send(8'h90); send(8'h3C); send(8'h64);
    idle(3);
    send(8'h40); send(8'h50);
    send(8'h80); send(8'h40); send(8'h00);
    send(8'h3C); send(8'h00);
    idle(3);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    idle(2);
    send(8'h80); send(8'h3C); send(8'h00);
    send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
    idle(4);

    send(8'h90);
    for (int i = 0; i <= DEPTH; i++) begin
      send(8'(8'h30 + i)); send(8'(8'h10 + i));
    end
    send(8'h80);
    for (int i = 1; i <= DEPTH; i += 2) begin
      send(8'(8'h30 + i)); send(8'h00);
    end
    idle(3);
    check("overflow_sticky", bus.overflow_o, 1);

    do_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h80); send(8'h30); send(8'h00);
    send(8'h90); send(8'h3C); send(8'h7F);
    send(8'h90); send(8'h3C);
    idle(3);
    do_reset();
    send(8'h64);
    idle(3);

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 29);
      if (r < 6) begin
        case ($urandom_range(0, 5))
          0: b = 8'h80;
          1: b = 8'h81;
          2: b = 8'h91;
          3: b = 8'hB0;
          default: b = 8'h90;
        endcase
      end else if (r < 27) begin
        b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'(8'h38 + $urandom_range(0, 11));
      end else if (r < 29) begin
        b = ($urandom_range(0, 1) == 0) ? 8'hF8 : 8'hFE;
      end else begin
        b = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF7;
      end
      send(b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(5);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
